// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control unit.
//   - state_t        : FSM state encoding
//   - field positions: opcode [15:11], register index [10:8], immediate/target [7:0]
//   - opcode constants and OP_PASS (ALU pass-through code)
//   - small opcode classification helpers
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam int unsigned OPC_W   = 5;
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 11;
    localparam int unsigned REG_MSB = 10;
    localparam int unsigned REG_LSB = 8;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OP_PASS      = 5'h00;
    localparam logic [OPC_W-1:0] OP_NOP       = 5'h00;
    localparam logic [OPC_W-1:0] OP_ALU_FIRST = 5'h01;
    localparam logic [OPC_W-1:0] OP_ALU_LAST  = 5'h0F;
    localparam logic [OPC_W-1:0] OP_ST        = 5'h10;
    localparam logic [OPC_W-1:0] OP_JMP       = 5'h11;
    localparam logic [OPC_W-1:0] OP_JZ        = 5'h12;
    localparam logic [OPC_W-1:0] OP_JLZ       = 5'h13;
    localparam logic [OPC_W-1:0] OP_JGZ       = 5'h14;
    localparam logic [OPC_W-1:0] OP_ILL_FIRST = 5'h15;
    localparam logic [OPC_W-1:0] OP_ILL_LAST  = 5'h1E;
    localparam logic [OPC_W-1:0] OP_HLT       = 5'h1F;

    function automatic logic is_alu(input logic [OPC_W-1:0] op);
        return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
    endfunction

    function automatic logic is_illegal(input logic [OPC_W-1:0] op);
        return (op >= OP_ILL_FIRST) && (op <= OP_ILL_LAST);
    endfunction

    // ALU ops forward their own code; everything else asks the ALU to pass.
    function automatic logic [OPC_W-1:0] alu_code(input logic [OPC_W-1:0] op);
        return is_alu(op) ? op : OP_PASS;
    endfunction

endpackage

// File: rtl/pc_cntr.sv
// pc_cntr: program counter with synchronous reset, load and wrapping increment.
//   clk, rst   : clock, synchronous active-high reset
//   load       : take load_val (has priority over inc)
//   inc        : count + 1, wrapping all-ones -> 0
//   count      : registered counter value
module pc_cntr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: FETCH -> DECODE -> EXECUTE sequencer for a small accumulator CPU.
//   clk, rst              : clock, synchronous active-high reset
//   instr, instr_valid    : program memory return path (used only while fetching)
//   zero_f/ls_z_f/gr_z_f  : ALU flags, sampled in EXECUTE for conditional jumps
//   pc, instr_req         : fetch address and request
//   we, dec_data          : accumulator load strobe and ALU operation
//   reg_sel, reg_we       : register-file store of the accumulator
//   imm_data              : zero-extended immediate
//   halted, illegal_op    : HLT reached / reserved opcode executed
// Optional macro CTRL_STEP_EN adds input step: each fetch waits for a step pulse.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int          UNDEFINED   = 0,
    parameter int unsigned CNTR_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned REG_BIT_CNT = 3,
    parameter int unsigned DATA_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  instr,
    input  logic                   instr_valid,
    input  logic                   zero_f,
    input  logic                   ls_z_f,
    input  logic                   gr_z_f,
    output logic [CNTR_WIDTH-1:0]  pc,
    output logic                   instr_req,
    output logic                   we,
    output logic [ADDR_WIDTH-1:0]  dec_data,
    output logic [REG_BIT_CNT-1:0] reg_sel,
    output logic                   reg_we,
    output logic [DATA_WIDTH-1:0]  imm_data,
    output logic                   halted,
    output logic                   illegal_op
`ifdef CTRL_STEP_EN
    ,
    input  logic                   step
`endif
);

    state_t                state;
    logic [DATA_WIDTH-1:0] ir;
    logic [OPC_W-1:0]      ir_op;
    logic                  take_jump_c;
    logic                  pc_load_c;
    logic                  pc_inc_c;
    logic                  go_c;

    assign ir_op = ir[OPC_MSB:OPC_LSB];

    // Field decoders shared by the FETCH capture and the DECODE refresh from IR.
    function automatic logic [ADDR_WIDTH-1:0] dec_of(input logic [DATA_WIDTH-1:0] w);
        return ADDR_WIDTH'(alu_code(w[OPC_MSB:OPC_LSB]));
    endfunction

    function automatic logic [REG_BIT_CNT-1:0] reg_of(input logic [DATA_WIDTH-1:0] w);
        return REG_BIT_CNT'(w[REG_MSB:REG_LSB]);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] imm_of(input logic [DATA_WIDTH-1:0] w);
        return DATA_WIDTH'(w[IMM_MSB:IMM_LSB]);
    endfunction

`ifdef CTRL_STEP_EN
    // A step pulse is remembered until the next fetch request consumes it.
    logic step_pend;
    logic arm_c;

    assign arm_c = ((state == ST_FETCH) && !instr_req) || (state == ST_EXECUTE);
    assign go_c  = step_pend | step;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_pend <= 1'b0;
        end else if (arm_c && go_c) begin
            step_pend <= 1'b0;
        end else if (step) begin
            step_pend <= 1'b1;
        end
    end
`else
    assign go_c = 1'b1;
`endif

    // Branch resolution uses the flags present during EXECUTE.
    always_comb begin
        take_jump_c = 1'b0;
        case (ir_op)
            OP_JMP:  take_jump_c = 1'b1;
            OP_JZ:   take_jump_c = zero_f;
            OP_JLZ:  take_jump_c = ls_z_f;
            OP_JGZ:  take_jump_c = gr_z_f;
            default: take_jump_c = 1'b0;
        endcase
        pc_load_c = (state == ST_EXECUTE) && take_jump_c;
        pc_inc_c  = (state == ST_EXECUTE) && !take_jump_c;
    end

    pc_cntr #(
        .WIDTH(CNTR_WIDTH)
    ) u_pc_cntr (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load_c),
        .inc      (pc_inc_c),
        .load_val (CNTR_WIDTH'(ir[IMM_MSB:IMM_LSB])),
        .count    (pc)
    );

    // Sequencer: outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FETCH;
            ir         <= '0;
            instr_req  <= 1'b0;
            we         <= 1'b0;
            reg_we     <= 1'b0;
            halted     <= 1'b0;
            illegal_op <= 1'b0;
            dec_data   <= ADDR_WIDTH'(UNDEFINED);
            reg_sel    <= REG_BIT_CNT'(UNDEFINED);
            imm_data   <= DATA_WIDTH'(UNDEFINED);
        end else begin
            we         <= 1'b0;
            reg_we     <= 1'b0;
            illegal_op <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (instr_req && instr_valid) begin
                        ir        <= instr;
                        state     <= ST_DECODE;
                        instr_req <= 1'b0;
                        dec_data  <= dec_of(instr);
                        reg_sel   <= reg_of(instr);
                        imm_data  <= imm_of(instr);
                    end else if (!instr_req && go_c) begin
                        instr_req <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (ir_op == OP_HLT) begin
                        state    <= ST_HALT;
                        halted   <= 1'b1;
                        dec_data <= ADDR_WIDTH'(UNDEFINED);
                        reg_sel  <= REG_BIT_CNT'(UNDEFINED);
                        imm_data <= DATA_WIDTH'(UNDEFINED);
                    end else begin
                        state      <= ST_EXECUTE;
                        we         <= is_alu(ir_op);
                        reg_we     <= (ir_op == OP_ST);
                        illegal_op <= is_illegal(ir_op);
                        dec_data   <= dec_of(ir);
                        reg_sel    <= reg_of(ir);
                        imm_data   <= imm_of(ir);
                    end
                end
                ST_EXECUTE: begin
                    state     <= ST_FETCH;
                    instr_req <= go_c;
                    dec_data  <= ADDR_WIDTH'(UNDEFINED);
                    reg_sel   <= REG_BIT_CNT'(UNDEFINED);
                    imm_data  <= DATA_WIDTH'(UNDEFINED);
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed sequences with literal
// expectations, then randomized stimulus, all checked every cycle against an
// instruction-level reference model.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        zero_f = 1'b0;
    logic        ls_z_f = 1'b0;
    logic        gr_z_f = 1'b0;
    logic [7:0]  pc;
    logic        instr_req;
    logic        we;
    logic [4:0]  dec_data;
    logic [2:0]  reg_sel;
    logic        reg_we;
    logic [15:0] imm_data;
    logic        halted;
    logic        illegal_op;
`ifdef CTRL_STEP_EN
    logic        step = 1'b1;
`endif

    always #5 clk = ~clk;

    control_unit dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .zero_f      (zero_f),
        .ls_z_f      (ls_z_f),
        .gr_z_f      (gr_z_f),
        .pc          (pc),
        .instr_req   (instr_req),
        .we          (we),
        .dec_data    (dec_data),
        .reg_sel     (reg_sel),
        .reg_we      (reg_we),
        .imm_data    (imm_data),
        .halted      (halted),
        .illegal_op  (illegal_op)
`ifdef CTRL_STEP_EN
        ,
        .step        (step)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: where the current instruction is in its life and what it is.
    int m_pc       = 0;
    bit m_fetching = 1'b1;
    bit m_req      = 1'b0;
    bit m_halted   = 1'b0;
    int m_age      = 0;     // 1 = being decoded, 2 = being executed
    int m_op       = 0;
    int m_reg      = 0;
    int m_imm      = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input logic [15:0] w, input bit v);
        bit take;
        if (r) begin
            m_pc = 0; m_fetching = 1'b1; m_req = 1'b0; m_halted = 1'b0;
            m_age = 0; m_op = 0; m_reg = 0; m_imm = 0;
        end else if (m_halted) begin
            // frozen until reset
        end else if (m_fetching) begin
            if (m_req && v) begin
                m_op = int'(w[15:11]); m_reg = int'(w[10:8]); m_imm = int'(w[7:0]);
                m_fetching = 1'b0; m_age = 1;
            end else begin
                m_req = 1'b1;
            end
        end else if (m_age == 1) begin
            if (m_op == 31) m_halted = 1'b1;
            else            m_age = 2;
        end else begin
            take = (m_op == 17) || (m_op == 18 && zero_f) ||
                   (m_op == 19 && ls_z_f) || (m_op == 20 && gr_z_f);
            m_pc = take ? m_imm : (m_pc + 1) % 256;
            m_fetching = 1'b1; m_req = 1'b1;
        end
    endtask

    task automatic compare();
        bit busy;
        bit exec;
        busy = !m_fetching && !m_halted;
        exec = busy && (m_age == 2);
        check("pc", pc, m_pc);
        check("instr_req", instr_req, m_fetching && m_req && !m_halted);
        check("halted", halted, m_halted);
        check("we", we, exec && m_op >= 1 && m_op <= 15);
        check("reg_we", reg_we, exec && m_op == 16);
        check("illegal_op", illegal_op, exec && m_op >= 21 && m_op <= 30);
        check("imm_data", imm_data, busy ? m_imm : 0);
        check("we_and_reg_we", we & reg_we, 0);
        if (busy) begin
            check("dec_data", dec_data, (m_op >= 1 && m_op <= 15) ? m_op : 0);
            check("reg_sel", reg_sel, m_reg);
        end
    endtask

    // One clock: apply inputs, let the edge happen, advance the model, compare.
    task automatic cycle(input bit r, input logic [15:0] w, input bit v);
        rst = r; instr = w; instr_valid = v;
        @(posedge clk);
        model_edge(r, w, v);
        #1;
        compare();
    endtask

    // Fetch then decode an instruction; returns with the DUT in EXECUTE.
    task automatic issue(input logic [15:0] w);
        cycle(1'b0, w, 1'b1);
        cycle(1'b0, w, 1'b0);
    endtask

    initial begin
        cycle(1'b1, 16'h0000, 1'b1);
        check("rst_pc", pc, 0);
        check("rst_req", instr_req, 0);
        check("rst_halted", halted, 0);

        cycle(1'b0, 16'h0000, 1'b1);
        check("req_after_rst", instr_req, 1);
        check("pc_after_rst", pc, 0);

        repeat (9) cycle(1'b0, 16'h0000, 1'b1);
        check("nop_stream_pc", pc, 3);

        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 16'h1800, 1'b0);
            check("wait_req", instr_req, 1);
            check("wait_pc", pc, 3);
        end
        issue(16'h1800);
        check("alu_we", we, 1);
        check("alu_dec", dec_data, 5'h03);
        cycle(1'b0, 16'h0000, 1'b0);
        check("alu_we_drop", we, 0);
        check("alu_pc", pc, 4);

        zero_f = 1'b1; issue(16'h9040); cycle(1'b0, 16'h0000, 1'b0);
        check("jz_taken", pc, 8'h40);
        zero_f = 1'b0; issue(16'h9040); cycle(1'b0, 16'h0000, 1'b0);
        check("jz_not_taken", pc, 8'h41);
        ls_z_f = 1'b1; issue(16'h9840); cycle(1'b0, 16'h0000, 1'b0);
        check("jlz_taken", pc, 8'h40);
        issue(16'hA040); cycle(1'b0, 16'h0000, 1'b0);
        check("jgz_not_taken", pc, 8'h41);
        gr_z_f = 1'b1; issue(16'hA040); cycle(1'b0, 16'h0000, 1'b0);
        check("jgz_taken", pc, 8'h40);
        ls_z_f = 1'b0; gr_z_f = 1'b0;

        issue(16'h88FF); cycle(1'b0, 16'h0000, 1'b0);
        check("jmp_pc", pc, 8'hFF);
        issue(16'h0000); cycle(1'b0, 16'h0000, 1'b0);
        check("pc_wrap", pc, 8'h00);

        issue(16'h8500);
        check("st_reg_we", reg_we, 1);
        check("st_reg_sel", reg_sel, 5);
        check("st_we", we, 0);
        cycle(1'b0, 16'h0000, 1'b0);
        check("st_pc", pc, 1);

        issue(16'hC000);
        check("ill_pulse", illegal_op, 1);
        cycle(1'b0, 16'h0000, 1'b0);
        check("ill_drop", illegal_op, 0);
        check("ill_pc", pc, 2);

        cycle(1'b0, 16'h0000, 1'b0);
        cycle(1'b1, 16'h0000, 1'b1);
        check("rst_mid_fetch_pc", pc, 0);
        check("rst_mid_fetch_req", instr_req, 0);
        cycle(1'b0, 16'h0000, 1'b0);
        issue(16'h0000); cycle(1'b0, 16'h0000, 1'b0);

        issue(16'hF800);
        check("hlt_halted", halted, 1);
        check("hlt_req", instr_req, 0);
        repeat (20) cycle(1'b0, 16'($urandom), 1'b1);
        check("hlt_stays", halted, 1);
        check("hlt_pc_frozen", pc, 1);
        cycle(1'b1, 16'h0000, 1'b0);
        check("rst_halt_pc", pc, 0);
        check("rst_halt_clr", halted, 0);
        cycle(1'b0, 16'h0000, 1'b0);
        check("req_after_halt_rst", instr_req, 1);

        for (int i = 0; i < 3000; i++) begin
            zero_f = 1'($urandom); ls_z_f = 1'($urandom); gr_z_f = 1'($urandom);
            cycle(($urandom_range(0, 99) == 0), 16'($urandom), ($urandom_range(0, 99) < 70));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
